// File: rtl/token_bucket_pkg.sv
// ---------------------------------------------------------------------------
// token_bucket_pkg
// Shared definitions for the token bucket rate limiter and any other
// throttling stage that consumes the pulser tick.
//   state_t    : throttle FSM encoding (READY=0, THROTTLED=1)
//   clog2()    : ceiling log2, used to size token counters
//   DROP_W     : width of the optional dropped-tick counter
// ---------------------------------------------------------------------------
package token_bucket_pkg;

  typedef enum logic {
    READY     = 1'b0,
    THROTTLED = 1'b1
  } state_t;

  localparam int DROP_W = 8;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/token_bucket_if.sv
// ---------------------------------------------------------------------------
// token_bucket_if
// Bundles the refill tick, the req/ack handshake and the bucket status.
//   tick       : refill event from the pulser (master -> slave)
//   req        : level request (master -> slave)
//   ack        : combinational grant, one token spent per ack (slave -> master)
//   tokens     : registered token count (slave -> master)
//   throttled  : FSM is in THROTTLED (slave -> master)
//   full       : tokens == depth (slave -> master)
//   drop_count : ticks lost while full, only with TOKEN_BUCKET_DROP_COUNT_EN
// ---------------------------------------------------------------------------
interface token_bucket_if
  import token_bucket_pkg::*;
#(
  parameter int TOK_W = 4
);
  logic             tick;
  logic             req;
  logic             ack;
  logic [TOK_W-1:0] tokens;
  logic             throttled;
  logic             full;
`ifdef TOKEN_BUCKET_DROP_COUNT_EN
  logic [DROP_W-1:0] drop_count;
`endif

  modport master (
    output tick,
    output req,
    input  ack,
    input  tokens,
    input  throttled,
`ifdef TOKEN_BUCKET_DROP_COUNT_EN
    input  drop_count,
`endif
    input  full
  );

  modport slave (
    input  tick,
    input  req,
    output ack,
    output tokens,
    output throttled,
`ifdef TOKEN_BUCKET_DROP_COUNT_EN
    output drop_count,
`endif
    output full
  );

endinterface

// File: rtl/token_bucket_tick_edge.sv
// ---------------------------------------------------------------------------
// token_bucket_tick_edge
// Turns the pulser output into a one-cycle refill strobe.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   i_tick       : pulser output (pulse or toggle level)
//   o_refill     : one refill event for this cycle
// TICK_TOGGLE=0 : tick is already a single-cycle pulse.
// TICK_TOGGLE=1 : tick is a toggle level; every edge counts as one refill.
// The delay register resets to 0 to match the pulser's toggle reset value,
// so the first toggle after reset is seen as an edge.
// ---------------------------------------------------------------------------
module token_bucket_tick_edge #(
  parameter int TICK_TOGGLE = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_tick,
  output logic o_refill
);

  logic r_tick_d;

  always_ff @(posedge clock) begin
    if (reset) r_tick_d <= 1'b0;
    else       r_tick_d <= i_tick;
  end

  assign o_refill = (TICK_TOGGLE != 0) ? (i_tick ^ r_tick_d) : i_tick;

endmodule

// File: rtl/token_bucket.sv
// ---------------------------------------------------------------------------
// token_bucket
// Rate limiter fed by the pulser tick. Each refill adds one token up to
// DEPTH; each ack spends one. Once the bucket drains the FSM throttles
// grants until the level recovers to THRESHOLD.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : tick, req in; ack, tokens, throttled, full out
// Parameters: DEPTH (>=1), THRESHOLD (1..DEPTH), INITIAL (0..DEPTH),
//   TICK_TOGGLE (0 pulse tick, 1 toggle tick).
// Optional: define TOKEN_BUCKET_DROP_COUNT_EN to add the saturating 8-bit
//   drop_count output (ticks lost while full).
// ---------------------------------------------------------------------------
module token_bucket
  import token_bucket_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int THRESHOLD   = 2,
  parameter int INITIAL     = 8,
  parameter int TICK_TOGGLE = 0
) (
  input  logic          clock,
  input  logic          reset,
  token_bucket_if.slave bus
);

  localparam int               TOK_W       = clog2(DEPTH + 1);
  localparam logic [TOK_W-1:0] DEPTH_T     = TOK_W'(DEPTH);
  localparam logic [TOK_W-1:0] THRESHOLD_T = TOK_W'(THRESHOLD);
  localparam logic [TOK_W-1:0] INITIAL_T   = TOK_W'(INITIAL);
  localparam state_t           RESET_STATE = (INITIAL >= THRESHOLD) ? READY : THROTTLED;
  localparam logic             RESET_FULL  = (INITIAL == DEPTH);

  logic [TOK_W-1:0] r_tokens;
  state_t           r_state;
  logic             r_full;

  logic             w_refill;
  logic             w_ack;
  logic             w_refill_ok;
  logic [TOK_W-1:0] w_next_tokens;

  token_bucket_tick_edge #(
    .TICK_TOGGLE (TICK_TOGGLE)
  ) u_tick_edge (
    .clock    (clock),
    .reset    (reset),
    .i_tick   (bus.tick),
    .o_refill (w_refill)
  );

  // Grant looks only at the registered level, so a refill arriving into an
  // empty bucket cannot be spent in the same cycle.
  assign w_ack = bus.req & (r_state == READY) & (r_tokens != '0) & ~reset;

  // A refill while full is kept only if a token leaves in the same cycle.
  assign w_refill_ok   = w_refill & ((r_tokens < DEPTH_T) | w_ack);
  assign w_next_tokens = r_tokens + TOK_W'(w_refill_ok) - TOK_W'(w_ack);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tokens <= INITIAL_T;
      r_state  <= RESET_STATE;
      r_full   <= RESET_FULL;
    end else begin
      r_tokens <= w_next_tokens;
      r_full   <= (w_next_tokens == DEPTH_T);
      case (r_state)
        READY:     if (w_next_tokens == '0)          r_state <= THROTTLED;
        THROTTLED: if (w_next_tokens >= THRESHOLD_T) r_state <= READY;
        default:                                     r_state <= RESET_STATE;
      endcase
    end
  end

`ifdef TOKEN_BUCKET_DROP_COUNT_EN
  logic [DROP_W-1:0] r_drop_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_refill & ~w_refill_ok & (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign bus.drop_count = r_drop_cnt;
`endif

  assign bus.ack       = w_ack;
  assign bus.tokens    = r_tokens;
  assign bus.throttled = (r_state == THROTTLED);
  assign bus.full      = r_full;

endmodule

// File: tb/tb_token_bucket.sv
// ---------------------------------------------------------------------------
// tb_token_bucket
// Directed bench for token_bucket with DEPTH=4, THRESHOLD=2.
//   dut0 : INITIAL=4, pulse tick (table-driven vectors)
//   dut1 : INITIAL=0, toggle tick (hand-written sequence)
// ---------------------------------------------------------------------------
module tb_token_bucket;
  import token_bucket_pkg::*;

  localparam int TW = clog2(5);

  logic clock;
  logic reset;
  int   total;
  int   bad;

  token_bucket_if #(.TOK_W(TW)) bus0 ();
  token_bucket_if #(.TOK_W(TW)) bus1 ();

  token_bucket #(
    .DEPTH(4), .THRESHOLD(2), .INITIAL(4), .TICK_TOGGLE(0)
  ) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  token_bucket #(
    .DEPTH(4), .THRESHOLD(2), .INITIAL(0), .TICK_TOGGLE(1)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic rst;
    logic tick;
    logic req;
    logic ack;
    int   tok;
    logic thr;
    logic full;
    int   drop;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic rst, input logic tick, input logic req,
                              input logic ack, input int tok, input logic thr,
                              input logic full, input int drop);
    vec_t v;
    v.rst = rst; v.tick = tick; v.req = req; v.ack = ack;
    v.tok = tok; v.thr = thr;   v.full = full; v.drop = drop;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int tk[5];
    int etok[5];
    int ethr[5];

    total = 0;
    bad   = 0;

    // Rows: inputs applied for one cycle; expectations are the outputs seen
    // before that cycle's clock edge (ack reflects this row's req).
    //              rst tick req  ack tok thr full drop
    vecs[0]  = mk(0, 0, 0,  0, 4, 0, 1, 0);  // idle, full
    vecs[1]  = mk(0, 0, 1,  1, 4, 0, 1, 0);  // drain 4 tokens
    vecs[2]  = mk(0, 0, 1,  1, 3, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1,  1, 2, 0, 0, 0);
    vecs[4]  = mk(0, 0, 1,  1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 1,  0, 0, 1, 0, 0);  // empty -> throttled
    vecs[6]  = mk(0, 0, 1,  0, 0, 1, 0, 0);
    vecs[7]  = mk(0, 1, 1,  0, 0, 1, 0, 0);  // refill+req on empty: no ack
    vecs[8]  = mk(0, 0, 1,  0, 1, 1, 0, 0);  // 1 token, still throttled
    vecs[9]  = mk(0, 1, 0,  0, 1, 1, 0, 0);  // second tick -> 2
    vecs[10] = mk(0, 0, 1,  1, 2, 0, 0, 0);  // ready again
    vecs[11] = mk(0, 1, 1,  1, 1, 0, 0, 0);  // tick+ack at 1
    vecs[12] = mk(0, 0, 0,  0, 1, 0, 0, 0);  // still 1, READY
    vecs[13] = mk(0, 1, 0,  0, 1, 0, 0, 0);  // refill up to 4
    vecs[14] = mk(0, 1, 0,  0, 2, 0, 0, 0);
    vecs[15] = mk(0, 1, 0,  0, 3, 0, 0, 0);
    vecs[16] = mk(0, 1, 0,  0, 4, 0, 1, 0);  // 3 ticks lost while full
    vecs[17] = mk(0, 1, 0,  0, 4, 0, 1, 1);
    vecs[18] = mk(0, 1, 0,  0, 4, 0, 1, 2);
    vecs[19] = mk(0, 0, 0,  0, 4, 0, 1, 3);
    vecs[20] = mk(0, 1, 1,  1, 4, 0, 1, 3);  // tick+ack while full
    vecs[21] = mk(0, 0, 0,  0, 4, 0, 1, 3);  // unchanged, no drop
    vecs[22] = mk(0, 0, 1,  1, 4, 0, 1, 3);  // drain again
    vecs[23] = mk(0, 0, 1,  1, 3, 0, 0, 3);
    vecs[24] = mk(0, 0, 1,  1, 2, 0, 0, 3);
    vecs[25] = mk(0, 0, 1,  1, 1, 0, 0, 3);
    vecs[26] = mk(0, 1, 0,  0, 0, 1, 0, 3);  // 1 token, throttled
    vecs[27] = mk(1, 1, 1,  0, 1, 1, 0, 3);  // reset with req and tick
    vecs[28] = mk(0, 0, 1,  1, 4, 0, 1, 0);  // reset values restored

    // Reset both instances with requests held high.
    reset     = 1'b1;
    bus0.tick = 1'b0; bus0.req = 1'b1;
    bus1.tick = 1'b0; bus1.req = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst ack0",  int'(bus0.ack),       0);
    check("rst ack1",  int'(bus1.ack),       0);
    check("rst tok0",  int'(bus0.tokens),    4);
    check("rst thr0",  int'(bus0.throttled), 0);
    check("rst full0", int'(bus0.full),      1);
    check("rst tok1",  int'(bus1.tokens),    0);
    check("rst thr1",  int'(bus1.throttled), 1);
    check("rst full1", int'(bus1.full),      0);
`ifdef TOKEN_BUCKET_DROP_COUNT_EN
    check("rst drop0", int'(bus0.drop_count), 0);
`endif

    reset    = 1'b0;
    bus0.req = 1'b0;
    #1;
    check("tog throttled ack", int'(bus1.ack), 0);
    bus1.req = 1'b0;

    // Toggle tick 0,1,1,0,0: refills only on the two level changes.
    tk   = '{0, 1, 1, 0, 0};
    etok = '{0, 1, 1, 2, 2};
    ethr = '{1, 1, 1, 0, 0};
    for (int k = 0; k < 5; k++) begin
      bus1.tick = tk[k][0];
      @(posedge clock);
      #1;
      check($sformatf("tog%0d tokens", k),    int'(bus1.tokens),    etok[k]);
      check($sformatf("tog%0d throttled", k), int'(bus1.throttled), ethr[k]);
    end
    bus1.req = 1'b1;
    #1;
    check("tog ack after recover", int'(bus1.ack), 1);
    bus1.req = 1'b0;

    // Table-driven run on the pulse-tick instance.
    for (int i = 0; i < 29; i++) begin
      reset     = vecs[i].rst;
      bus0.tick = vecs[i].tick;
      bus0.req  = vecs[i].req;
      @(negedge clock);
      check($sformatf("row%0d ack", i),       int'(bus0.ack),       int'(vecs[i].ack));
      check($sformatf("row%0d tokens", i),    int'(bus0.tokens),    vecs[i].tok);
      check($sformatf("row%0d throttled", i), int'(bus0.throttled), int'(vecs[i].thr));
      check($sformatf("row%0d full", i),      int'(bus0.full),      int'(vecs[i].full));
`ifdef TOKEN_BUCKET_DROP_COUNT_EN
      check($sformatf("row%0d drop", i),      int'(bus0.drop_count), vecs[i].drop);
`endif
      @(posedge clock);
      #1;
    end

    bus0.req  = 1'b0;
    bus0.tick = 1'b0;
    reset     = 1'b0;
    #1;
    check("end tokens", int'(bus0.tokens), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
